// File: rtl/mux_pipe_pkg.sv
// mux_pipe_pkg
// Shared definitions for the pipelined N-bit selector family.
//   MUX_DEF_N, MUX_DEF_NUM_IN, MUX_DEF_GROUP : default parameter values
//   clog2(value)       : ceiling log2, usable in constant expressions
//   ceilDiv(num, den)  : ceiling integer division, usable in constant expressions
package mux_pipe_pkg;

  localparam int MUX_DEF_N      = 32;
  localparam int MUX_DEF_NUM_IN = 32;
  localparam int MUX_DEF_GROUP  = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int ceilDiv(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/mux_pipe_slice.sv
// mux_pipe_slice
// Generic valid/ready register slice of width W. Holds one data word and its
// valid bit; accepts new contents when empty or when the current contents are
// being taken downstream in the same cycle.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_valid, i_data    upstream word and its valid
//   o_ready            slice will load this cycle (upstream may advance)
//   o_valid, o_data    registered word presented downstream
//   i_ready            downstream takes the registered word this cycle
module mux_pipe_slice
  import mux_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  // Load when empty or when the held word leaves this cycle; this is what
  // gives one transfer per cycle with no bubble after a stall.
  assign w_load  = !r_valid || i_ready;
  assign o_ready = w_load;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Data only moves with a valid word so a bubble leaves the last value
  // in place instead of toggling the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/mux_nbit_pipe.sv
// mux_nbit_pipe
// Two-stage pipelined NUM_IN-way, N-bit selector with valid/ready on both
// sides. Stage 1 selects within each GROUP-wide group of inputs, stage 2
// selects the group. Inputs past NUM_IN in the last group read as zero.
// Optional feature macro: MUX_NBIT_PIPE_SEL_CHECK_EN
//   defined   : out_err flags selects >= NUM_IN (data forced to 0) and a
//               simulation assertion flags such requests on acceptance
//   undefined : out_err is tied low, no range compare is built
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data  [NUM_IN*N]  flattened inputs, input k at [k*N +: N]
//   in_sel   [SEL_W]     index of the input to forward
//   in_valid / in_ready  request handshake
//   out_data [N]         selected data
//   out_sel  [SEL_W]     select value that produced out_data
//   out_err              result came from an out-of-range select
//   out_valid / out_ready result handshake
module mux_nbit_pipe
  import mux_pipe_pkg::*;
#(
  parameter int N      = MUX_DEF_N,
  parameter int NUM_IN = MUX_DEF_NUM_IN,
  parameter int GROUP  = MUX_DEF_GROUP,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IN*N-1:0] in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_err
);

  localparam int LG      = clog2(GROUP);
  localparam int NUM_GRP = ceilDiv(NUM_IN, GROUP);
  localparam int PAD_IN  = NUM_GRP * GROUP;
  localparam int S1_W    = NUM_GRP * N + SEL_W;
  localparam int S2_W    = 1 + SEL_W + N;

  logic [PAD_IN*N-1:0]  w_padded;
  logic [LG-1:0]        w_lowSel;
  logic [NUM_GRP*N-1:0] w_s1Cand;

  logic                 w_s1Valid;
  logic [S1_W-1:0]      w_s1Out;
  logic [SEL_W-1:0]     w_s1Sel;
  logic [NUM_GRP*N-1:0] w_s1CandR;

  logic                 w_s2Load;
  int                   w_grpIdx;
  logic [N-1:0]         w_s2Data;
  logic [N-1:0]         w_s2DataMasked;
  logic                 w_s2Err;
  logic [S2_W-1:0]      w_s2Out;

  // Zero-extending the flat input bus fills the unused tail of the last
  // group with zeros, so padded positions read 0 without extra muxing.
  assign w_padded = (PAD_IN*N)'(in_data);

  // When the whole select fits in one group the low select is simply the
  // zero-extended select; otherwise it is the low LG bits.
  assign w_lowSel = LG'(in_sel);

  for (genvar g = 0; g < NUM_GRP; g++) begin : gen_grp
    assign w_s1Cand[g*N +: N] = w_padded[(g*GROUP + int'(w_lowSel))*N +: N];
  end

  mux_pipe_slice #(.W(S1_W)) u_stage1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (in_valid),
    .i_data  ({in_sel, w_s1Cand}),
    .o_ready (in_ready),
    .o_valid (w_s1Valid),
    .o_data  (w_s1Out),
    .i_ready (w_s2Load)
  );

  assign w_s1Sel   = w_s1Out[S1_W-1 -: SEL_W];
  assign w_s1CandR = w_s1Out[NUM_GRP*N-1:0];

  // Group index is computed as an int so a select narrower than one group
  // (single-group configuration) cleanly yields group 0.
  assign w_grpIdx = int'(w_s1Sel) >> LG;

  // A group index past the last real group selects nothing and yields 0.
  always_comb begin
    w_s2Data = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (w_grpIdx == g) w_s2Data = w_s1CandR[g*N +: N];
    end
  end

`ifdef MUX_NBIT_PIPE_SEL_CHECK_EN
  assign w_s2Err        = (int'(w_s1Sel) >= NUM_IN);
  assign w_s2DataMasked = w_s2Err ? '0 : w_s2Data;

  selInRange : assert property (@(posedge clk) disable iff (!rst_n)
    !(in_valid && in_ready && (int'(in_sel) >= NUM_IN)));
`else
  assign w_s2Err        = 1'b0;
  assign w_s2DataMasked = w_s2Data;
`endif

  mux_pipe_slice #(.W(S2_W)) u_stage2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_s1Valid),
    .i_data  ({w_s2Err, w_s1Sel, w_s2DataMasked}),
    .o_ready (w_s2Load),
    .o_valid (out_valid),
    .o_data  (w_s2Out),
    .i_ready (out_ready)
  );

  assign out_err  = w_s2Out[S2_W-1];
  assign out_sel  = w_s2Out[N +: SEL_W];
  assign out_data = w_s2Out[N-1:0];

endmodule

// File: tb/tb_mux_nbit_pipe.sv
// tb_mux_nbit_pipe
// Self-checking bench for mux_nbit_pipe. Three instances cover the default
// 32-input build (A), a 24-input non-power-of-two build (B) and a single-group
// 4-input build (C). Each instance has a scoreboard queue fed on request
// acceptance and drained on output transfer.
module tb_mux_nbit_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  sel;
    logic        err;
  } exp_t;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] expData;
    logic        oor;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cycle = 0;
  int   nCompared = 0;
  int   nMismatched = 0;

  // Instance A: 32 inputs, groups of 8
  logic [32*32-1:0] aInData;
  logic [4:0]       aInSel;
  logic             aInValid, aInReady, aOutValid, aOutReady, aOutErr;
  logic [31:0]      aOutData;
  logic [4:0]       aOutSel;
  exp_t             aExpNext;
  exp_t             aQ[$];
  int               aXferCycle[$];
  int               aAcceptCnt = 0, aXferCnt = 0, aValidCnt = 0;

  // Instance B: 24 inputs, groups of 8
  logic [24*32-1:0] bInData;
  logic [4:0]       bInSel;
  logic             bInValid, bInReady, bOutValid, bOutReady, bOutErr;
  logic [31:0]      bOutData;
  logic [4:0]       bOutSel;
  exp_t             bExpNext;
  exp_t             bQ[$];
  int               bXferCnt = 0;

  // Instance C: 4 inputs, single group of 8
  logic [4*32-1:0]  cInData;
  logic [1:0]       cInSel;
  logic             cInValid, cInReady, cOutValid, cOutReady, cOutErr;
  logic [31:0]      cOutData;
  logic [1:0]       cOutSel;
  exp_t             cExpNext;
  exp_t             cQ[$];
  int               cXferCycle[$];
  int               cXferCnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  mux_nbit_pipe #(.N(32), .NUM_IN(32), .GROUP(8)) dutA (
    .clk(clk), .rst_n(rst_n), .in_data(aInData), .in_sel(aInSel),
    .in_valid(aInValid), .in_ready(aInReady), .out_data(aOutData),
    .out_sel(aOutSel), .out_valid(aOutValid), .out_ready(aOutReady),
    .out_err(aOutErr)
  );

  mux_nbit_pipe #(.N(32), .NUM_IN(24), .GROUP(8)) dutB (
    .clk(clk), .rst_n(rst_n), .in_data(bInData), .in_sel(bInSel),
    .in_valid(bInValid), .in_ready(bInReady), .out_data(bOutData),
    .out_sel(bOutSel), .out_valid(bOutValid), .out_ready(bOutReady),
    .out_err(bOutErr)
  );

  mux_nbit_pipe #(.N(32), .NUM_IN(4), .GROUP(8)) dutC (
    .clk(clk), .rst_n(rst_n), .in_data(cInData), .in_sel(cInSel),
    .in_valid(cInValid), .in_ready(cInReady), .out_data(cOutData),
    .out_sel(cOutSel), .out_valid(cOutValid), .out_ready(cOutReady),
    .out_err(cOutErr)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic errModel(input logic oor);
`ifdef MUX_NBIT_PIPE_SEL_CHECK_EN
    return oor;
`else
    return 1'b0 & oor;
`endif
  endfunction

  // Drives one cycle of instance A; input k of A always carries A5000000+k.
  task automatic applyStimulus(input logic [4:0] sel, input logic valid,
                               input logic outReady);
    @(negedge clk);
    aInSel    = sel;
    aInValid  = valid;
    aOutReady = outReady;
    aExpNext  = '{data: 32'hA500_0000 + {27'd0, sel}, sel: sel, err: 1'b0};
    #2;
  endtask

  task automatic drainA(input string name);
    for (int i = 0; i < 20 && aQ.size() != 0; i++) applyStimulus(5'd0, 1'b0, 1'b1);
    checkOutput(name, 64'(aQ.size()), 64'(0));
  endtask

  // Scoreboard monitors sample 1 time unit after the falling edge, once the
  // drivers have settled the inputs for the cycle.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) aQ.delete();
    else begin
      if (aInValid && aInReady) begin
        aQ.push_back(aExpNext);
        aAcceptCnt++;
      end
      if (aOutValid) aValidCnt++;
      if (aOutValid && aOutReady) begin
        aXferCnt++;
        aXferCycle.push_back(cycle);
        if (aQ.size() == 0) checkOutput("A spurious output", 64'(aOutData), 64'(0));
        else begin
          e = aQ.pop_front();
          checkOutput("A out_data", 64'(aOutData), 64'(e.data));
          checkOutput("A out_sel", 64'(aOutSel), 64'(e.sel));
          checkOutput("A out_err", 64'(aOutErr), 64'(e.err));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) bQ.delete();
    else begin
      if (bInValid && bInReady) bQ.push_back(bExpNext);
      if (bOutValid && bOutReady) begin
        bXferCnt++;
        if (bQ.size() == 0) checkOutput("B spurious output", 64'(bOutData), 64'(0));
        else begin
          e = bQ.pop_front();
          checkOutput("B out_data", 64'(bOutData), 64'(e.data));
          checkOutput("B out_sel", 64'(bOutSel), 64'(e.sel));
          checkOutput("B out_err", 64'(bOutErr), 64'(e.err));
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) cQ.delete();
    else begin
      if (cInValid && cInReady) cQ.push_back(cExpNext);
      if (cOutValid && cOutReady) begin
        cXferCnt++;
        cXferCycle.push_back(cycle);
        if (cQ.size() == 0) checkOutput("C spurious output", 64'(cOutData), 64'(0));
        else begin
          e = cQ.pop_front();
          checkOutput("C out_data", 64'(cOutData), 64'(e.data));
          checkOutput("C out_sel", 64'(cOutSel), 64'(e.sel));
          checkOutput("C out_err", 64'(cOutErr), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got time limit reached, expected run complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    int   base, acc, vbase, k, startCycle;

    tbl[0] = '{sel: 5'd0,  expData: 32'hB000_0000, oor: 1'b0};
    tbl[1] = '{sel: 5'd7,  expData: 32'hB000_0007, oor: 1'b0};
    tbl[2] = '{sel: 5'd8,  expData: 32'hB000_0008, oor: 1'b0};
    tbl[3] = '{sel: 5'd15, expData: 32'hB000_000F, oor: 1'b0};
    tbl[4] = '{sel: 5'd16, expData: 32'hB000_0010, oor: 1'b0};
    tbl[5] = '{sel: 5'd23, expData: 32'hB000_0017, oor: 1'b0};
    tbl[6] = '{sel: 5'd27, expData: 32'h0000_0000, oor: 1'b1};
    tbl[7] = '{sel: 5'd12, expData: 32'hB000_000C, oor: 1'b0};
    tbl[8] = '{sel: 5'd24, expData: 32'h0000_0000, oor: 1'b1};

    for (int i = 0; i < 32; i++) aInData[i*32 +: 32] = 32'hA500_0000 + i;
    for (int i = 0; i < 24; i++) bInData[i*32 +: 32] = 32'hB000_0000 + i;
    for (int i = 0; i < 4; i++)  cInData[i*32 +: 32] = 32'hC0DE_0000 + i;
    aInSel = '0; aInValid = 1'b0; aOutReady = 1'b0; aExpNext = '0;
    bInSel = '0; bInValid = 1'b0; bOutReady = 1'b0; bExpNext = '0;
    cInSel = '0; cInValid = 1'b0; cOutReady = 1'b0; cExpNext = '0;

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset A out_valid", 64'(aOutValid), 64'(0));
    checkOutput("reset A out_data", 64'(aOutData), 64'(0));
    checkOutput("reset A out_sel", 64'(aOutSel), 64'(0));
    checkOutput("reset A out_err", 64'(aOutErr), 64'(0));
    checkOutput("reset A in_ready", 64'(aInReady), 64'(1));
    checkOutput("reset B out_valid", 64'(bOutValid), 64'(0));
    checkOutput("reset C out_valid", 64'(cOutValid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back stream of all 32 selects
    $display("[TB] stream 0..31");
    base = aXferCnt;
    startCycle = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 1'b1, 1'b1);
      if (i == 0) startCycle = cycle;
      checkOutput("stream in_ready", 64'(aInReady), 64'(1));
    end
    drainA("stream drain");
    checkOutput("stream count", 64'(aXferCnt - base), 64'(32));
    if (aXferCycle.size() >= base + 32) begin
      checkOutput("stream latency", 64'(aXferCycle[base] - startCycle), 64'(2));
      checkOutput("stream throughput", 64'(aXferCycle[base+31] - aXferCycle[base]), 64'(31));
    end

    // Fill, stall for 5 cycles, release
    $display("[TB] stall and release");
    base = aXferCnt;
    acc  = aAcceptCnt;
    k    = 5;
    repeat (2) begin
      applyStimulus(5'(k), 1'b1, 1'b0);
      if (aInReady) k++;
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'(k), 1'b1, 1'b0);
      checkOutput("stall in_ready", 64'(aInReady), 64'(0));
      checkOutput("stall out_valid", 64'(aOutValid), 64'(1));
      checkOutput("stall out_data hold", 64'(aOutData), 64'(32'hA500_0005));
      checkOutput("stall out_sel hold", 64'(aOutSel), 64'(5));
      if (aInReady) k++;
    end
    checkOutput("stall accepted", 64'(aAcceptCnt - acc), 64'(2));
    checkOutput("stall no transfer", 64'(aXferCnt - base), 64'(0));
    for (int i = 0; i < 6; i++) begin
      applyStimulus(5'(k), 1'b1, 1'b1);
      if (i == 0) checkOutput("release in_ready", 64'(aInReady), 64'(1));
      if (aInReady) k++;
    end
    checkOutput("release zero bubble", 64'(aXferCnt - base), 64'(6));
    drainA("stall drain");
    checkOutput("stall no loss", 64'(aXferCnt - base), 64'(aAcceptCnt - acc));

    // Reset with both stages full
    $display("[TB] reset mid-stream");
    applyStimulus(5'd20, 1'b1, 1'b0);
    applyStimulus(5'd21, 1'b1, 1'b0);
    applyStimulus(5'd22, 1'b0, 1'b0);
    checkOutput("pre-reset out_valid", 64'(aOutValid), 64'(1));
    checkOutput("pre-reset in_ready", 64'(aInReady), 64'(0));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", 64'(aOutValid), 64'(0));
    checkOutput("async reset out_data", 64'(aOutData), 64'(0));
    checkOutput("async reset in_ready", 64'(aInReady), 64'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    aOutReady = 1'b1;
    #2;
    checkOutput("post-reset in_ready", 64'(aInReady), 64'(1));
    vbase = aValidCnt;
    repeat (5) applyStimulus(5'd0, 1'b0, 1'b1);
    checkOutput("no stale output", 64'(aValidCnt - vbase), 64'(0));

    // Table of boundary and out-of-range selects on the 24-input build
    $display("[TB] table vectors on 24-input build");
    base = bXferCnt;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bInValid  = 1'b1;
      bOutReady = 1'b1;
      bInSel    = tbl[i].sel;
      bExpNext  = '{data: tbl[i].expData, sel: tbl[i].sel, err: errModel(tbl[i].oor)};
      #2;
    end
    @(negedge clk);
    bInValid = 1'b0;
    for (int i = 0; i < 20 && bQ.size() != 0; i++) @(negedge clk);
    #2;
    checkOutput("table drain", 64'(bQ.size()), 64'(0));
    checkOutput("table count", 64'(bXferCnt - base), 64'(9));

    // Random valid/ready on the 24-input build
    $display("[TB] random traffic on 24-input build");
    base = bXferCnt;
    for (int cyc = 0; cyc < 60000 && (bXferCnt - base) < 10000; cyc++) begin
      @(negedge clk);
      for (int j = 0; j < 24; j++) bInData[j*32 +: 32] = $urandom();
      bInSel    = 5'($urandom_range(0, 23));
      bInValid  = 1'($urandom_range(0, 1));
      bOutReady = 1'($urandom_range(0, 1));
      bExpNext  = '{data: bInData[int'(bInSel)*32 +: 32], sel: bInSel, err: 1'b0};
      #2;
    end
    checkOutput("random transfers reached", 64'((bXferCnt - base) >= 10000), 64'(1));
    @(negedge clk);
    bInValid  = 1'b0;
    bOutReady = 1'b1;
    for (int i = 0; i < 20 && bQ.size() != 0; i++) @(negedge clk);
    #2;
    checkOutput("random drain", 64'(bQ.size()), 64'(0));

    // Single-group build
    $display("[TB] single-group build");
    base = cXferCnt;
    startCycle = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cInValid  = 1'b1;
      cOutReady = 1'b1;
      cInSel    = 2'(i);
      cExpNext  = '{data: 32'hC0DE_0000 + 32'(i), sel: 5'(i), err: 1'b0};
      #2;
      if (i == 0) startCycle = cycle;
      checkOutput("C in_ready", 64'(cInReady), 64'(1));
    end
    @(negedge clk);
    cInValid = 1'b0;
    for (int i = 0; i < 20 && cQ.size() != 0; i++) @(negedge clk);
    #2;
    checkOutput("C count", 64'(cXferCnt - base), 64'(4));
    if (cXferCycle.size() >= base + 4) begin
      checkOutput("C latency", 64'(cXferCycle[base] - startCycle), 64'(2));
      checkOutput("C throughput", 64'(cXferCycle[base+3] - cXferCycle[base]), 64'(3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
